// File: rtl/fifo_data_producer.sv
// Write-domain burst source for the async FIFO: emits burst_len words (count or LFSR)
// on wr_enable_fifo/wr_data and stalls on the FIFO's combinational full flag.
module fifo_data_producer #(
  parameter int                   DATA_W     = 8,
  parameter int                   LEN_W      = 8,
  parameter int                   GAP_CYCLES = 2,
  parameter logic [DATA_W-1:0]    LFSR_SEED  = 8'hA5
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              full,
  output logic              wr_enable_fifo,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        burst_count
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [LEN_W:0]      rem_q, rem_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                mode_q, mode_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                accept;

  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] d);
    logic fb;
    if (DATA_W == 8) fb = d[7] ^ d[5] ^ d[4] ^ d[3];
    else             fb = d[DATA_W-1] ^ d[DATA_W-2];
    return {d[DATA_W-2:0], fb};
  endfunction

  // Must be the exact term the FIFO uses to advance its write pointer.
  assign accept = wen_q & ~full;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    mode_d  = mode_q;
    wen_d   = wen_q;
    data_d  = data_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          // A zero length encodes the full 2^LEN_W words, hence the extra counter bit.
          rem_d   = (burst_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, burst_len};
          data_d  = mode ? LFSR_SEED : '0;
          wen_d   = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (rem_q > (LEN_W+1)'(1)) begin
            rem_d  = rem_q - (LEN_W+1)'(1);
            data_d = mode_q ? lfsr_next(data_q) : data_q + DATA_W'(1);
          end else begin
            rem_d  = '0;
            wen_d  = 1'b0;
            done_d = 1'b1;
            cnt_d  = cnt_q + 8'd1;
            if (GAP_CYCLES == 0) begin
              state_d = S_IDLE;
            end else begin
              gap_d   = GAP_W'(GAP_CYCLES);
              state_d = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      mode_q  <= 1'b0;
      wen_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      mode_q  <= mode_d;
      wen_q   <= wen_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wr_enable_fifo = wen_q;
  assign wr_data        = data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign burst_count    = cnt_q;

endmodule

// File: tb/tb_fifo_data_producer.sv
// Bench for fifo_data_producer: table of bursts plus hand sequences for real-FIFO stall and reset.
module tb_fifo_data_producer;

  logic       wclk;
  logic       wrst_n;
  logic       start;
  logic       mode;
  logic [7:0] burst_len;
  logic       full;
  logic       full_drv;
  logic       fifo_mode;
  logic       rd_en;
  logic       wr_enable_fifo;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic [7:0] burst_count;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  int fcount;
  logic [7:0] exp_q[$];
  logic [7:0] acc_log[$];

  typedef struct {
    bit         mode;
    logic [7:0] len;
    int         stall_at;
    int         stall_len;
    bit         hold;
    int         exp_lat;
    int         exp_bc;
    logic [7:0] w0, w1, w2, wl;
  } vec_t;

  vec_t tbl[5];

  fifo_data_producer #(.DATA_W(8), .LEN_W(8), .GAP_CYCLES(2), .LFSR_SEED(8'hA5)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .start(start), .mode(mode), .burst_len(burst_len),
    .full(full), .wr_enable_fifo(wr_enable_fifo), .wr_data(wr_data), .busy(busy),
    .done(done), .burst_count(burst_count)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  assign full = fifo_mode ? (fcount == 8) : full_drv;

  // Depth-8 FIFO occupancy model standing in for the real write/read pointer logic.
  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) fcount <= 0;
    else if (fifo_mode)
      fcount <= fcount + ((wr_enable_fifo && !full) ? 1 : 0) - ((rd_en && fcount > 0) ? 1 : 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr(input logic [7:0] d);
    return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
  endfunction

  // Scoreboard: a write is committed at the coming edge when wr_enable_fifo & ~full.
  always @(negedge wclk) begin
    if (wrst_n === 1'b1 && wr_enable_fifo === 1'b1 && full === 1'b0) begin
      n_acc++;
      acc_log.push_back(wr_data);
      if (exp_q.size() == 0) chk("unexpected_write", {24'd0, wr_data}, 32'hFFFF_FFFF);
      else chk("word", {24'd0, wr_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic push_words(input bit m, input int nw);
    logic [7:0] w;
    w = m ? 8'hA5 : 8'h00;
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back(w);
      w = m ? lfsr(w) : w + 8'd1;
    end
  endtask

  task automatic launch(input bit m, input logic [7:0] len);
    acc_log.delete();
    n_acc = 0;
    @(posedge wclk); #1;
    start = 1'b1; mode = m; burst_len = len;
    @(posedge wclk); #1;
  endtask

  task automatic run_row(input vec_t v);
    int nw, lat, stall_left;
    nw = (v.len == 0) ? 256 : int'(v.len);
    push_words(v.mode, nw);
    launch(v.mode, v.len);
    if (!v.hold) start = 1'b0;
    stall_left = v.stall_len;
    lat = -1;
    for (int k = 1; k <= 600 && lat < 0; k++) begin
      @(posedge wclk); #1;
      if (v.stall_len > 0 && n_acc == v.stall_at && stall_left > 0) begin
        full_drv = 1'b1;
        stall_left--;
      end else begin
        full_drv = 1'b0;
      end
      @(negedge wclk);
      if (full_drv && exp_q.size() > 0) begin
        chk("hold_data", {24'd0, wr_data}, {24'd0, exp_q[0]});
        chk("hold_wen", {31'd0, wr_enable_fifo}, 32'd1);
      end
      if (done === 1'b1) lat = k;
    end
    full_drv = 1'b0;
    chk("done_latency", lat, v.exp_lat);
    chk("burst_count", {24'd0, burst_count}, v.exp_bc);
    chk("wen_after_done", {31'd0, wr_enable_fifo}, 32'd0);
    chk("busy_at_done", {31'd0, busy}, 32'd1);
    @(posedge wclk); #1;
    @(negedge wclk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_gap", {31'd0, busy}, 32'd1);
    @(posedge wclk); #1;
    start = 1'b0;
    @(negedge wclk);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    @(posedge wclk); #1;
    @(negedge wclk);
    chk("no_restart_busy", {31'd0, busy}, 32'd0);
    chk("no_restart_wen", {31'd0, wr_enable_fifo}, 32'd0);
    chk("words_accepted", acc_log.size(), nw);
    chk("word0", (acc_log.size() > 0) ? {24'd0, acc_log[0]} : 32'hFFFF_FFFF, v.w0);
    chk("word1", (acc_log.size() > 1) ? {24'd0, acc_log[1]} : 32'hFFFF_FFFF, v.w1);
    chk("word2", (acc_log.size() > 2) ? {24'd0, acc_log[2]} : 32'hFFFF_FFFF, v.w2);
    chk("word_last", (acc_log.size() > 0) ? {24'd0, acc_log[acc_log.size()-1]} : 32'hFFFF_FFFF, v.wl);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vec_t fresh;
    //          mode len    stall_at len hold lat bc  w0     w1     w2     wlast
    tbl[0] = '{1'b0, 8'd4, 0, 0, 1'b0, 4,   1, 8'h00, 8'h01, 8'h02, 8'h03};
    tbl[1] = '{1'b1, 8'd3, 0, 0, 1'b0, 3,   2, 8'hA5, 8'h4A, 8'h95, 8'h95};
    tbl[2] = '{1'b0, 8'd4, 2, 3, 1'b0, 7,   3, 8'h00, 8'h01, 8'h02, 8'h03};
    tbl[3] = '{1'b1, 8'd5, 1, 1, 1'b0, 6,   4, 8'hA5, 8'h4A, 8'h95, 8'h54};
    tbl[4] = '{1'b0, 8'd0, 0, 0, 1'b1, 256, 5, 8'h00, 8'h01, 8'h02, 8'hFF};

    wrst_n = 1'b1; start = 1'b0; mode = 1'b0; burst_len = 8'd0;
    full_drv = 1'b0; fifo_mode = 1'b0; rd_en = 1'b0;
    #2 wrst_n = 1'b0;
    #1;
    chk("rst_wen", {31'd0, wr_enable_fifo}, 32'd0);
    chk("rst_data", {24'd0, wr_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_count", {24'd0, burst_count}, 32'd0);
    @(negedge wclk); #1 wrst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_row(tbl[i]);

    // Real FIFO with stalled reader: 8 words fill it, then full holds word 08.
    fifo_mode = 1'b1; rd_en = 1'b0;
    push_words(1'b0, 10);
    launch(1'b0, 8'd10);
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge wclk); #1;
    end
    @(negedge wclk);
    chk("fifo_full", {31'd0, full}, 32'd1);
    chk("fifo_stall_accepts", n_acc, 8);
    chk("fifo_stall_data", {24'd0, wr_data}, 32'h08);
    chk("fifo_stall_wen", {31'd0, wr_enable_fifo}, 32'd1);
    chk("fifo_stall_done", {31'd0, done}, 32'd0);
    @(posedge wclk); #1 rd_en = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge wclk);
      if (done === 1'b1) lat = k;
      @(posedge wclk); #1;
    end
    chk("fifo_done_seen", (lat > 0) ? 1 : 0, 1);
    chk("fifo_total_accepts", n_acc, 10);
    chk("fifo_last_word", (acc_log.size() > 0) ? {24'd0, acc_log[acc_log.size()-1]} : 32'hFFFF_FFFF, 32'h09);
    chk("fifo_burst_count", {24'd0, burst_count}, 32'd6);
    chk("fifo_scoreboard_empty", exp_q.size(), 0);
    for (int k = 0; k < 12; k++) begin
      @(posedge wclk); #1;
    end
    fifo_mode = 1'b0; rd_en = 1'b0;

    // Asynchronous reset after the 2nd accept of a 6-word burst.
    push_words(1'b0, 6);
    launch(1'b0, 8'd6);
    start = 1'b0;
    for (int k = 1; k <= 20 && n_acc < 2; k++) begin
      @(posedge wclk); #1;
    end
    #2 wrst_n = 1'b0;
    #1;
    chk("mid_rst_wen", {31'd0, wr_enable_fifo}, 32'd0);
    chk("mid_rst_data", {24'd0, wr_data}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_count", {24'd0, burst_count}, 32'd0);
    chk("mid_rst_accepts", n_acc, 2);
    exp_q.delete();
    @(negedge wclk); #1 wrst_n = 1'b1;
    @(negedge wclk);
    chk("post_rst_count", {24'd0, burst_count}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    fresh = '{1'b0, 8'd4, 0, 0, 1'b0, 4, 1, 8'h00, 8'h01, 8'h02, 8'h03};
    run_row(fresh);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
